hamming_secded_codec: RTL and testbench
=======================================

Name: hamming_secded_codec

Overview:
- Parametrised, pipelined extended-Hamming SECDED codec: single-error correction, double-error detection.
- Runtime-selectable encode or decode per word, with valid/ready handshakes on both sides.
- Optional single-bit error injection on encode, for self-test.
- Saturating counters of corrected and uncorrectable words.
- Sits between a data source and a storage or serial link. It replaces the fixed 4-bit combinational codec in the TinyTapeout top.

Parameters:
- DATA_W, 4, payload width in bits; legal range 4..57.
- P_W, derived (localparam), smallest p with 2^p >= DATA_W+p+1 (3 for DATA_W=4).
- CW_W, derived (localparam), DATA_W+P_W+1, codeword width including overall parity (8 for DATA_W=4).
- CNT_W, 8, width of each error counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- mode  in  1  0 = encode, 1 = decode; sampled with each accepted input word.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept an input word.
- in_data  in  CW_W  encode: payload in bits [DATA_W-1:0], upper bits ignored; decode: full codeword.
- err_inj_en  in  1  encode only: flip one codeword bit before output.
- err_inj_pos  in  $clog2(CW_W)  index of the bit to flip; sampled with the input word.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts the output word.
- out_data  out  CW_W  encode: codeword; decode: corrected payload in [DATA_W-1:0], upper bits 0.
- out_err_single  out  1  decode: single error corrected (includes an error on the overall parity bit).
- out_err_double  out  1  decode: uncorrectable error detected.
- cnt_clr  in  1  synchronous clear of both counters.
- corr_cnt  out  CNT_W  count of corrected words, saturating.
- uncorr_cnt  out  CNT_W  count of uncorrectable words, saturating.

Behaviour:
- Codeword layout:
  - bit 0 is the overall even parity over all CW_W bits;
  - bits at power-of-two positions 1, 2, 4, … carry Hamming parity;
  - payload bits fill the remaining positions in ascending order, payload bit 0 first.
- Parity bit at position 2^k = XOR of every position i in 1..CW_W-1 with bit k of i set.
- Syndrome S = XOR of the indices of all set bits in positions 1..CW_W-1. P = XOR of all CW_W bits.
- Decode classification:
  - S=0, P=0: clean; both flags 0.
  - P=1, S=0: overall parity bit in error; payload unchanged; out_err_single=1.
  - P=1, 0<S<CW_W: flip bit S; out_err_single=1.
  - P=1, S>=CW_W: treated as uncorrectable; out_err_double=1; payload passed uncorrected.
  - P=0, S!=0: out_err_double=1; payload passed uncorrected.
- Encode: both flags are always 0. Injection occurs only if err_inj_en=1 and err_inj_pos<CW_W; an out-of-range position is ignored.
- Pipeline:
  - Stage 1 registers the input word, mode and injection controls, plus the computed syndrome/parity (decode) or the parity bits (encode).
  - Stage 2 registers out_data and the flags.
  - Latency is 2 cycles from input handshake to out_valid. Throughput is 1 word/cycle while out_ready=1.
- Handshake:
  - A stage loads when it is empty or its contents are moving downstream in the same cycle.
  - in_ready = !s1_valid || (!s2_valid || out_ready); combinational, may depend on out_ready.
  - out_data and the flags stay stable while out_valid=1 and out_ready=0.
  - No word is dropped or duplicated under any pattern of backpressure.
- Counters:
  - They update on an output handshake of a decode word: corr_cnt on a single error, uncorr_cnt on a double error.
  - They saturate at 2^CNT_W-1.
  - cnt_clr takes priority over a same-cycle increment.
- Reset:
  - Asserting rst at any time clears both stage valids, out_valid, out_data, both flags and both counters to 0, and discards in-flight words.
  - in_ready is 1 while rst is deasserted and the pipeline is empty.
- mode may change on every word; each word is processed according to its own sampled mode.

Decomposition:
- Shared package hamming_pkg holds:
  - function calc_p_w(data_w);
  - function is_pow2(pos);
  - function data_pos(idx), mapping a payload index to a codeword position.
- Natural sub-module: hamming_secded_core, purely combinational. It provides encode(payload) -> codeword and syndrome(codeword) -> {S, P}. It is instantiated once per pipeline stage as needed.

Test Plan (DATA_W=4, CW_W=8):
- Encode in_data=0xB, err_inj_en=0 -> out_data=0xAA two cycles later, both flags 0.
- Decode 0xAA -> out_data=0x0B, flags 0, counters unchanged. Decode 0xEA (bit 6 flipped) -> out_data=0x0B, out_err_single=1, corr_cnt=1.
- Decode 0xE2 (bits 6 and 3 flipped) -> out_data=0x0E, out_err_double=1, uncorr_cnt=1. Decode 0xAB (bit 0 flipped) -> out_data=0x0B, out_err_single=1.
- Encode 0xB with err_inj_en=1, err_inj_pos=5 -> out_data=0x8A. Loop this output back as a decode word -> out_data=0x0B, out_err_single=1.
- Stream 8 alternating encode/decode words with out_ready toggling pseudo-randomly -> all 8 outputs in order, none lost, outputs stable while stalled; then 300 single-error decodes -> corr_cnt=255; cnt_clr together with an increment -> 0.
- Assert rst with two words in flight -> out_valid=0 immediately, counters 0, in_ready=1 after release, and no stale word appears.

Source files
------------

// File: rtl/hamming_secded_codec_pkg.sv
// Shared helpers for the extended-Hamming SECDED codec: parity sizing and
// the payload-to-codeword position map.
package hamming_pkg;

   function automatic int calc_p_w(input int data_w);
      int p;
      p = 0;
      // descending scan leaves the smallest qualifying p
      for (int q = 7; q >= 1; q--) begin
         if ((1 << q) >= data_w + q + 1) p = q;
      end
      return p;
   endfunction

   function automatic bit is_pow2(input int pos);
      return (pos > 0) && ((pos & (pos - 1)) == 0);
   endfunction

   function automatic int data_pos(input int idx);
      int cnt;
      int res;
      cnt = 0;
      res = 0;
      for (int p = 3; p < 64; p++) begin
         if (!is_pow2(p) && res == 0) begin
            if (cnt == idx) res = p;
            cnt++;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/hamming_secded_codec_core.sv
// Combinational SECDED kernel: payload -> full codeword, and
// received word -> {syndrome, overall parity}.
module hamming_secded_core
   import hamming_pkg::*;
#(
   parameter  int DATA_W = 4,
   localparam int P_W    = calc_p_w(DATA_W),
   localparam int CW_W   = DATA_W + P_W + 1
) (
   input  logic [DATA_W-1:0] payload,
   output logic [CW_W-1:0]   codeword,
   input  logic [CW_W-1:0]   rx_word,
   output logic [P_W-1:0]    syndrome,
   output logic              parity
);

   logic [CW_W-1:0] placed;
   logic [CW_W-1:0] body;
   logic [P_W-1:0]  checks;

   // Hamming parity bits equal the XOR of the positions of set payload bits.
   always_comb begin
      placed = '0;
      for (int unsigned i = 0; i < DATA_W; i++) placed[data_pos(i)] = payload[i];
      checks = '0;
      for (int unsigned i = 0; i < CW_W; i++) begin
         if (placed[i]) checks = checks ^ i[P_W-1:0];
      end
      body = placed;
      for (int unsigned k = 0; k < P_W; k++) body[1 << k] = checks[k];
      codeword    = body;
      codeword[0] = ^body;
   end

   always_comb begin
      syndrome = '0;
      for (int unsigned i = 0; i < CW_W; i++) begin
         if (rx_word[i]) syndrome = syndrome ^ i[P_W-1:0];
      end
      parity = ^rx_word;
   end

endmodule

// File: rtl/hamming_secded_codec.sv
// Two-stage pipelined SECDED encoder/decoder with valid/ready on both sides,
// encode-side error injection and saturating error counters.
module hamming_secded_codec
   import hamming_pkg::*;
#(
   parameter  int DATA_W = 4,
   parameter  int CNT_W  = 8,
   localparam int P_W    = calc_p_w(DATA_W),
   localparam int CW_W   = DATA_W + P_W + 1,
   localparam int POS_W  = $clog2(CW_W)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mode,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [CW_W-1:0]  in_data,
   input  logic             err_inj_en,
   input  logic [POS_W-1:0] err_inj_pos,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CW_W-1:0]  out_data,
   output logic             out_err_single,
   output logic             out_err_double,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] corr_cnt,
   output logic [CNT_W-1:0] uncorr_cnt
);

   logic             s1_valid, s1_mode, s1_inj_en, s1_par;
   logic [POS_W-1:0] s1_inj_pos;
   logic [CW_W-1:0]  s1_word;
   logic [P_W-1:0]   s1_syn;
   logic             s2_valid, s2_mode;
   logic             s1_load, s2_load, out_fire;
   logic [CW_W-1:0]  enc_word;
   logic [P_W-1:0]   syn;
   logic             par;
   logic [CW_W-1:0]  s2_data_d;
   logic             single_d, double_d;

   hamming_secded_core #(.DATA_W(DATA_W)) u_core (
      .payload  (in_data[DATA_W-1:0]),
      .codeword (enc_word),
      .rx_word  (in_data),
      .syndrome (syn),
      .parity   (par)
   );

   assign s2_load   = !s2_valid || out_ready;
   assign s1_load   = !s1_valid || s2_load;
   assign in_ready  = s1_load;
   assign out_valid = s2_valid;
   assign out_fire  = s2_valid && out_ready;

   // Stage 1 holds the finished codeword for encode words, so stage 2 only
   // applies injection; for decode words it holds the raw word plus {S, P}.
   always_comb begin
      s2_data_d = '0;
      single_d  = 1'b0;
      double_d  = 1'b0;
      if (!s1_mode) begin
         s2_data_d = s1_word ^ ((s1_inj_en && int'(s1_inj_pos) < CW_W)
                                ? (CW_W'(1) << s1_inj_pos) : '0);
      end else begin
         single_d = s1_par && (int'(s1_syn) < CW_W);
         double_d = !single_d && (s1_par || s1_syn != '0);
         for (int unsigned i = 0; i < DATA_W; i++) begin
            s2_data_d[i] = s1_word[data_pos(i)] ^ (single_d && int'(s1_syn) == data_pos(i));
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid       <= 1'b0;
         s1_mode        <= 1'b0;
         s1_inj_en      <= 1'b0;
         s1_inj_pos     <= '0;
         s1_word        <= '0;
         s1_syn         <= '0;
         s1_par         <= 1'b0;
         s2_valid       <= 1'b0;
         s2_mode        <= 1'b0;
         out_data       <= '0;
         out_err_single <= 1'b0;
         out_err_double <= 1'b0;
      end else begin
         if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
               s1_mode    <= mode;
               s1_inj_en  <= err_inj_en;
               s1_inj_pos <= err_inj_pos;
               s1_word    <= mode ? in_data : enc_word;
               s1_syn     <= syn;
               s1_par     <= par;
            end
         end
         if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               s2_mode        <= s1_mode;
               out_data       <= s2_data_d;
               out_err_single <= single_d;
               out_err_double <= double_d;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         corr_cnt   <= '0;
         uncorr_cnt <= '0;
      end else if (cnt_clr) begin
         corr_cnt   <= '0;
         uncorr_cnt <= '0;
      end else if (out_fire && s2_mode) begin
         if (out_err_single && corr_cnt != '1)   corr_cnt   <= corr_cnt + CNT_W'(1);
         if (out_err_double && uncorr_cnt != '1) uncorr_cnt <= uncorr_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hamming_secded_codec.sv
// Self-checking bench for hamming_secded_codec (DATA_W=4, CW_W=8): fixed
// vectors, randomized traffic against a reference model, and corner sequences.
module tb_hamming_secded_codec;

   logic       clk, rst, mode, in_valid, in_ready, err_inj_en;
   logic [7:0] in_data, out_data, corr_cnt, uncorr_cnt;
   logic [2:0] err_inj_pos;
   logic       out_valid, out_ready, out_err_single, out_err_double, cnt_clr;

   hamming_secded_codec #(.DATA_W(4), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .err_inj_en(err_inj_en), .err_inj_pos(err_inj_pos),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_err_single(out_err_single), .out_err_double(out_err_double),
      .cnt_clr(cnt_clr), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      bit         s;
      bit         d;
      bit         m;
      int         cyc;
   } exp_t;

   typedef struct {
      bit         m;
      logic [7:0] din;
      bit         ie;
      logic [2:0] ip;
      logic [7:0] dout;
      bit         s;
      bit         d;
   } vec_t;

   int         checks = 0, passes = 0, cyc = 0, n_sent = 0, n_seen = 0;
   int         m_corr = 0, m_uncorr = 0;
   exp_t       q[$];
   exp_t       pend;
   bit         accepted, stalled, rand_ready, check_lat;
   logic [10:0] snap;
   logic [7:0] last_out;
   vec_t       tbl[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic fail(input string name, input string why);
      checks++;
      $display("FAIL %s: %s (t=%0t)", name, why, $time);
   endtask

   // Reference: parity bits are the XOR of positions holding set payload bits.
   function automatic logic [7:0] m_encode(input logic [3:0] d, input bit inj, input int pos);
      logic [7:0] cw;
      int s, n;
      cw = '0; s = 0; n = 0;
      for (int p = 1; p < 8; p++) begin
         if ((p & (p - 1)) != 0) begin
            cw[p] = d[n];
            if (d[n]) s = s ^ p;
            n++;
         end
      end
      for (int k = 0; k < 3; k++) cw[1 << k] = s[k];
      cw[0] = ^cw;
      if (inj) cw[pos] = ~cw[pos];
      return cw;
   endfunction

   function automatic void m_decode(input logic [7:0] cw, output logic [7:0] d,
                                    output bit s1, output bit d2);
      logic [7:0] c;
      int s;
      c = cw; s = 0; s1 = 0; d2 = 0;
      for (int p = 1; p < 8; p++) if (cw[p]) s = s ^ p;
      if (^cw) begin
         if (s < 8) begin s1 = 1; c[s] = ~c[s]; end
         else d2 = 1;
      end else if (s != 0) d2 = 1;
      d = {4'b0, c[7], c[6], c[5], c[3]};
   endfunction

   function automatic logic [7:0] rand_cw(input int nflip);
      logic [7:0] cw;
      int a, b;
      cw = m_encode(4'($urandom_range(0, 15)), 0, 0);
      a = $urandom_range(0, 7);
      if (nflip >= 1) cw[a] = ~cw[a];
      if (nflip == 2) begin
         b = (a + $urandom_range(1, 7)) % 8;
         cw[b] = ~cw[b];
      end
      return cw;
   endfunction

   // One clock: check counters and output handshake at negedge, return at posedge+1.
   task automatic step();
      exp_t e;
      @(negedge clk);
      cyc++;
      chk("corr_cnt", 32'(corr_cnt), 32'(m_corr));
      chk("uncorr_cnt", 32'(uncorr_cnt), 32'(m_uncorr));
      if (stalled)
         chk("stall_hold", 32'({out_valid, out_err_single, out_err_double, out_data}), 32'(snap));
      stalled = 0;
      if (out_valid) begin
         if (out_ready) begin
            if (q.size() == 0) fail("unexpected_output", "out_valid with no word outstanding");
            else begin
               e = q.pop_front();
               n_seen++;
               chk("out_data", 32'(out_data), 32'(e.data));
               chk("err_single", 32'(out_err_single), 32'(e.s));
               chk("err_double", 32'(out_err_double), 32'(e.d));
               if (check_lat) chk("latency", 32'(cyc - e.cyc), 32'd2);
               last_out = out_data;
               if (e.m && e.s && m_corr < 255) m_corr++;
               if (e.m && e.d && m_uncorr < 255) m_uncorr++;
            end
         end else begin
            stalled = 1;
            snap = {out_valid, out_err_single, out_err_double, out_data};
         end
      end
      if (cnt_clr) begin m_corr = 0; m_uncorr = 0; end
      accepted = in_valid && in_ready;
      if (accepted) begin
         pend.cyc = cyc;
         q.push_back(pend);
         n_sent++;
      end
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic send(input bit m, input logic [7:0] din, input bit ie, input logic [2:0] ip,
                       input logic [7:0] ed, input bit es, input bit edd);
      mode = m; in_data = din; err_inj_en = ie; err_inj_pos = ip; in_valid = 1;
      pend.data = ed; pend.s = es; pend.d = edd; pend.m = m; pend.cyc = 0;
      accepted = 0;
      for (int i = 0; i < 60 && !accepted; i++) step();
      if (!accepted) fail("in_handshake", "word not accepted within 60 cycles");
      in_valid = 0;
   endtask

   task automatic send_model(input bit m, input logic [7:0] din, input bit ie, input logic [2:0] ip);
      logic [7:0] ed;
      bit es, edd;
      if (!m) begin ed = m_encode(din[3:0], ie, int'(ip)); es = 0; edd = 0; end
      else m_decode(din, ed, es, edd);
      send(m, din, ie, ip, ed, es, edd);
   endtask

   task automatic drain();
      for (int i = 0; i < 80 && q.size() > 0; i++) step();
      if (q.size() > 0) fail("drain", "outputs still outstanding after 80 cycles");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1; mode = 0; in_valid = 0; in_data = '0; err_inj_en = 0; err_inj_pos = '0;
      out_ready = 1; cnt_clr = 0; rand_ready = 0; check_lat = 0; stalled = 0; last_out = '0;

      tbl[0] = '{0, 8'h0B, 0, 3'd0, 8'hAA, 0, 0};
      tbl[1] = '{1, 8'hAA, 0, 3'd0, 8'h0B, 0, 0};
      tbl[2] = '{1, 8'hEA, 0, 3'd0, 8'h0B, 1, 0};
      tbl[3] = '{1, 8'hE2, 0, 3'd0, 8'h0E, 0, 1};
      tbl[4] = '{1, 8'hAB, 0, 3'd0, 8'h0B, 1, 0};
      tbl[5] = '{0, 8'hFB, 0, 3'd0, 8'hAA, 0, 0};
      tbl[6] = '{0, 8'h0F, 0, 3'd0, 8'hFF, 0, 0};
      tbl[7] = '{1, 8'hAA, 1, 3'd3, 8'h0B, 0, 0};
      tbl[8] = '{0, 8'h0B, 1, 3'd5, 8'h8A, 0, 0};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_flags", 32'({out_err_single, out_err_double}), 32'd0);
      chk("rst_counters", 32'({corr_cnt, uncorr_cnt}), 32'd0);
      rst = 0;
      #1 chk("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      check_lat = 1;
      foreach (tbl[i]) send(tbl[i].m, tbl[i].din, tbl[i].ie, tbl[i].ip, tbl[i].dout, tbl[i].s, tbl[i].d);
      drain();
      check_lat = 0;
      chk("table_corr_cnt", 32'(corr_cnt), 32'd2);
      chk("table_uncorr_cnt", 32'(uncorr_cnt), 32'd1);

      send(1, last_out, 0, 3'd0, 8'h0B, 1, 0);
      drain();
      chk("loopback_corr_cnt", 32'(corr_cnt), 32'd3);

      rand_ready = 1;
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) send_model(0, 8'($urandom), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
         else            send_model(1, rand_cw($urandom_range(0, 2)), 0, 3'd0);
      end
      drain();
      for (int i = 0; i < 200; i++) begin
         repeat ($urandom_range(0, 1)) step();
         if ($urandom_range(0, 1) == 0)
            send_model(0, 8'($urandom), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
         else
            send_model(1, rand_cw($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      end
      drain();
      chk("words_in_equals_out", 32'(n_seen), 32'(n_sent));
      rand_ready = 0;
      out_ready = 1;

      for (int i = 0; i < 300; i++) send_model(1, rand_cw(1), 0, 3'd0);
      drain();
      chk("corr_saturated", 32'(corr_cnt), 32'd255);

      cnt_clr = 1;
      send_model(1, rand_cw(1), 0, 3'd0);
      drain();
      cnt_clr = 0;
      chk("clr_over_incr_corr", 32'(corr_cnt), 32'd0);
      chk("clr_over_incr_uncorr", 32'(uncorr_cnt), 32'd0);

      send(1, 8'hEA, 0, 3'd0, 8'h0B, 1, 0);
      drain();
      chk("pre_rst_corr", 32'(corr_cnt), 32'd1);
      out_ready = 0;
      send(1, 8'hAB, 0, 3'd0, 8'h0B, 1, 0);
      send(0, 8'h0B, 0, 3'd0, 8'hAA, 0, 0);
      #2 rst = 1;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_out_data", 32'(out_data), 32'd0);
      chk("midrst_counters", 32'({corr_cnt, uncorr_cnt}), 32'd0);
      q.delete();
      m_corr = 0; m_uncorr = 0; stalled = 0;
      @(posedge clk);
      #1 rst = 0;
      #1 chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      out_ready = 1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("no_stale_word", 32'(out_valid), 32'd0);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
